memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter_pkg.sv | 22 ++
 rtl/memory_arbiter_priority_select.sv | 15 +
 rtl/memory_arbiter.sv | 93 +++++++++
 tb/tb_memory_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types for the pipeline memory-port arbiter.
package memory_arbiter_pkg;
    localparam int XLEN     = 32;
    localparam int NClients = 3;

    typedef logic [XLEN-1:0] regval_t;

    typedef enum logic [1:0] {
        ClientFetch = 2'd0,
        ClientRead  = 2'd1,
        ClientWrite = 2'd2
    } client_t;

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbBusy = 1'b1
    } arb_state_t;

    function automatic logic [NClients-1:0] client_mask(client_t c, logic en);
        return en ? NClients'(1) << c : '0;
    endfunction
endpackage

// File: rtl/memory_arbiter_priority_select.sv
// priority_select: combinational write > read > fetch pick, with a fetch override
// once fetch has been starved long enough.
module priority_select
    import memory_arbiter_pkg::*;
(
    input  logic [NClients-1:0] i_req,
    input  logic                i_fetch_boost,
    output client_t             o_grant,
    output logic                o_grant_valid
);
    assign o_grant = (i_fetch_boost && i_req[ClientFetch]) ? ClientFetch :
                     i_req[ClientWrite]                    ? ClientWrite :
                     i_req[ClientRead]                     ? ClientRead  : ClientFetch;
    assign o_grant_valid = |i_req;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises fetch/read/write clients onto one memory port,
// one transaction at a time, with fetch anti-starvation and a bus timeout.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int StarveLimit   = 8,
    parameter int TimeoutCycles = 64,
    parameter int TW            = 7
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    input  logic [NClients-1:0]            i_req,
    input  logic [NClients-1:0]            i_is_write,
    input  logic [NClients-1:0][XLEN-1:0]  i_address,
    input  logic [NClients-1:0][XLEN-1:0]  i_wdata,
    output logic [NClients-1:0]            o_data_valid,
    output logic [NClients-1:0]            o_error,
    output logic [XLEN-1:0]                o_rdata,
    output logic                           o_mem_address_enable,
    output logic                           o_mem_write_enable,
    output logic [XLEN-1:0]                o_mem_address,
    output logic [XLEN-1:0]                o_mem_wdata,
    input  logic [XLEN-1:0]                i_mem_rdata,
    input  logic                           i_mem_data_valid
);
    localparam int SW = $clog2(StarveLimit + 1);

    arb_state_t    r_state;
    client_t       r_owner;
    logic          r_is_write;
    regval_t       r_address;
    regval_t       r_wdata;
    logic [SW-1:0] r_starve;
    logic [TW-1:0] r_timeout;

    client_t w_grant;
    logic    w_grant_valid;
    logic    w_boost;
    logic    w_busy;
    logic    w_done;
    logic    w_expire;

    assign w_boost  = r_starve >= SW'(StarveLimit);
    assign w_busy   = r_state == ArbBusy;
    assign w_done   = w_busy && i_mem_data_valid;
    // Completion takes precedence over a timeout landing in the same cycle.
    assign w_expire = w_busy && !i_mem_data_valid && r_timeout == TW'(TimeoutCycles - 1);

    priority_select u_priority_select (
        .i_req         (i_req),
        .i_fetch_boost (w_boost),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // Strobes are qualified by the owner's live request so a flushed client sees nothing.
    assign o_data_valid         = client_mask(r_owner, w_done && i_req[r_owner]);
    assign o_error              = client_mask(r_owner, w_expire && i_req[r_owner]);
    assign o_rdata              = w_done ? i_mem_rdata : '0;
    assign o_mem_address_enable = w_busy;
    assign o_mem_write_enable   = w_busy && r_is_write;
    assign o_mem_address        = w_busy ? r_address : '0;
    assign o_mem_wdata          = w_busy ? r_wdata : '0;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ArbIdle;
            r_owner    <= ClientFetch;
            r_is_write <= 1'b0;
            r_address  <= '0;
            r_wdata    <= '0;
            r_starve   <= '0;
            r_timeout  <= '0;
        end else if (r_state == ArbIdle) begin
            if (w_grant_valid) begin
                r_state    <= ArbBusy;
                r_owner    <= w_grant;
                r_is_write <= i_is_write[w_grant];
                r_address  <= i_address[w_grant];
                r_wdata    <= i_wdata[w_grant];
                r_timeout  <= '0;
                if (w_grant == ClientFetch)
                    r_starve <= '0;
                else if (i_req[ClientFetch] && !w_boost)
                    r_starve <= r_starve + 1'b1;
            end
        end else begin
            r_timeout <= r_timeout + 1'b1;
            if (w_done || w_expire)
                r_state <= ArbIdle;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level reference of the arbitration rules.
module tb_memory_arbiter;
    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       req = '0;
    logic [2:0]       is_write = '0;
    logic [2:0][31:0] addr = '0;
    logic [2:0][31:0] wdata = '0;
    logic [31:0]      mem_rdata = '0;
    logic             mem_dv = 1'b0;
    logic [2:0]       o_dv, o_err;
    logic [31:0]      o_rdata, o_maddr, o_mwdata;
    logic             o_mae, o_mwe;

    int n_checks = 0;
    int n_errors = 0;

    // reference state: one outstanding transaction, its age, fetch's losses
    bit          m_busy = 0;
    int          m_owner = 0;
    int          m_age = 0;
    int          m_lost = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;

    logic [2:0]  sticky = '0;
    logic        s_ae, s_we;
    logic [31:0] s_addr;
    logic [2:0]  s_dv, s_err;

    memory_arbiter dut (
        .i_clock              (clk),
        .i_reset_n            (reset_n),
        .i_req                (req),
        .i_is_write           (is_write),
        .i_address            (addr),
        .i_wdata              (wdata),
        .o_data_valid         (o_dv),
        .o_error              (o_err),
        .o_rdata              (o_rdata),
        .o_mem_address_enable (o_mae),
        .o_mem_write_enable   (o_mwe),
        .o_mem_address        (o_maddr),
        .o_mem_wdata          (o_mwdata),
        .i_mem_rdata          (mem_rdata),
        .i_mem_data_valid     (mem_dv)
    );

    always #5 clk = ~clk;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_idle_outputs(string tag);
        check_eq({tag, "_mae"}, 32'(o_mae), 0);
        check_eq({tag, "_mwe"}, 32'(o_mwe), 0);
        check_eq({tag, "_maddr"}, o_maddr, 0);
        check_eq({tag, "_mwdata"}, o_mwdata, 0);
        check_eq({tag, "_dv"}, 32'(o_dv), 0);
        check_eq({tag, "_err"}, 32'(o_err), 0);
        check_eq({tag, "_rdata"}, o_rdata, 0);
    endtask

    // Hold reset low, check outputs asynchronously, release after the next edge.
    task automatic do_reset(string tag);
        reset_n = 1'b0;
        #2;
        check_idle_outputs(tag);
        m_busy = 0; m_age = 0; m_lost = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One clock: compare at negedge, advance the reference at posedge,
    // then clients drop requests that just completed (unless sticky).
    task automatic cycle();
        logic done, tmo;
        logic [2:0] e_dv, e_err;
        int w;
        @(negedge clk);
        done  = m_busy && mem_dv;
        tmo   = m_busy && !mem_dv && m_age == 63;
        e_dv  = (done && req[m_owner]) ? 3'(1 << m_owner) : 3'b0;
        e_err = (tmo && req[m_owner]) ? 3'(1 << m_owner) : 3'b0;
        s_ae = o_mae; s_we = o_mwe; s_addr = o_maddr; s_dv = o_dv; s_err = o_err;
        check_eq("mem_address_enable", 32'(o_mae), 32'(m_busy));
        if (m_busy) begin
            check_eq("mem_write_enable", 32'(o_mwe), 32'(m_we));
            check_eq("mem_address", o_maddr, m_addr);
            check_eq("mem_wdata", o_mwdata, m_wdata);
        end
        check_eq("data_valid", 32'(o_dv), 32'(e_dv));
        check_eq("error", 32'(o_err), 32'(e_err));
        if (done) check_eq("rdata", o_rdata, mem_rdata);
        @(posedge clk);
        if (!m_busy) begin
            if (req != 0) begin
                if (req[0] && m_lost >= 8) w = 0;
                else if (req[2]) w = 2;
                else if (req[1]) w = 1;
                else w = 0;
                if (w == 0) m_lost = 0;
                else if (req[0]) m_lost = (m_lost < 8) ? m_lost + 1 : 8;
                m_busy = 1; m_owner = w; m_age = 0;
                m_we = is_write[w]; m_addr = addr[w]; m_wdata = wdata[w];
            end
        end else if (done || tmo) m_busy = 0;
        else m_age++;
        #1;
        req = req & ~((e_dv | e_err) & ~sticky);
    endtask

    initial begin
        int n, reads, found;
        logic [5:0] pat;
        logic [31:0] order [3];
        #7;
        do_reset("reset");

        // single store, memory answers in the third BUSY cycle
        is_write = 3'b100; addr[2] = 32'h100; wdata[2] = 32'hDEADBEEF; req = 3'b100;
        n = 0; reads = 0;
        for (int i = 0; i < 6; i++) begin
            mem_dv = (i == 3);
            cycle();
            if (s_we && s_addr == 32'h100) n++;
            if (s_dv[2]) reads++;
        end
        check_eq("store_busy_cycles", n, 3);
        check_eq("store_dv_pulses", reads, 1);

        // three-way contention with zero-latency memory
        is_write = 3'b000; addr[0] = 32'hA0; addr[1] = 32'hB0; addr[2] = 32'hC0;
        req = 3'b111; mem_dv = 1'b1; pat = '0; n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            pat = {pat[4:0], s_ae};
            if (s_ae && n < 3) begin order[n] = s_addr; n++; end
        end
        check_eq("three_ae_pattern", 32'(pat), 32'b010101);
        check_eq("grant_first", order[0], 32'hC0);
        check_eq("grant_second", order[1], 32'hB0);
        check_eq("grant_third", order[2], 32'hA0);

        // fetch starvation: read re-requests every IDLE cycle
        req = 3'b000; mem_dv = 1'b0;
        cycle();
        do_reset("reset_pre_starve");
        addr[0] = 32'hF0; addr[1] = 32'h10; req = 3'b011; sticky = 3'b011; mem_dv = 1'b1;
        for (int round = 0; round < 2; round++) begin
            reads = 0; found = 0;
            for (int i = 0; i < 40 && found == 0; i++) begin
                cycle();
                if (s_ae && s_addr == 32'h10) reads++;
                else if (s_ae && s_addr == 32'hF0) found = 1;
            end
            check_eq("starve_losses", reads, 8);
            check_eq("starve_fetch_granted", found, 1);
        end
        sticky = '0; req = '0; mem_dv = 1'b0;
        cycle(); cycle();

        // silent memory: read times out, pending fetch is granted next
        addr[1] = 32'h200; req = 3'b011; n = 0;
        for (int i = 0; i < 80 && s_err == 0; i++) begin
            if (i == 0) s_err = '0;
            cycle();
            if (s_ae) n++;
        end
        check_eq("timeout_busy_cycles", n, 64);
        check_eq("timeout_error", 32'(s_err), 32'b010);
        mem_dv = 1'b0;
        cycle();
        mem_dv = 1'b1;
        cycle();
        check_eq("after_timeout_fetch", s_addr, 32'hF0);
        mem_dv = 1'b0; req = '0;
        cycle();

        // completion in the final timeout cycle wins
        req = 3'b010;
        cycle();
        repeat (63) cycle();
        mem_dv = 1'b1;
        cycle();
        check_eq("last_cycle_dv", 32'(s_dv), 32'b010);
        check_eq("last_cycle_err", 32'(s_err), 0);
        mem_dv = 1'b0; req = '0;
        cycle();

        // fetch flush mid-BUSY, read waiting behind it
        req = 3'b001; cycle();
        req = 3'b011; cycle();
        req = 3'b010; cycle();
        cycle();
        mem_dv = 1'b1; cycle();
        check_eq("flush_dv", 32'(s_dv), 0);
        mem_dv = 1'b0; cycle();
        mem_dv = 1'b1; cycle();
        check_eq("flush_read_granted", s_addr, 32'h200);
        mem_dv = 1'b0; req = '0;
        cycle();

        // reset during BUSY with memory responding
        req = 3'b100; is_write = 3'b100; cycle(); cycle();
        mem_dv = 1'b1;
        do_reset("reset_mid_busy");
        mem_dv = 1'b0;
        cycle();
        cycle();
        check_eq("post_reset_grant", s_addr, 32'hC0);
        mem_dv = 1'b1; cycle();
        mem_dv = 1'b0; req = '0; cycle();

        // randomized traffic with periodic silent-memory windows
        for (int cyc = 0; cyc < 2400; cyc++) begin
            for (int c = 0; c < 3; c++) begin
                if (req[c] && c == 0 && $urandom_range(39) == 0) req[c] = 1'b0;
                else if (!req[c] && $urandom_range(3) == 0) req[c] = 1'b1;
                addr[c] = $urandom; wdata[c] = $urandom;
            end
            is_write = 3'($urandom);
            mem_rdata = $urandom;
            mem_dv = ((cyc / 300) % 4 == 3) ? 1'b0 : ($urandom_range(2) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
